// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: 2*BIT_WIDTH dividend / BIT_WIDTH divisor, restoring shift-subtract, one bit per clock.
// Fixed latency of 2*BIT_WIDTH+2 cycles per division; start is ignored while busy, results held until the next divide.
module seq_signed_divider #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2*BIT_WIDTH-1:0] dividend,
  input  logic [BIT_WIDTH-1:0]   divisor,
  output logic [BIT_WIDTH-1:0]   quotient,
  output logic [BIT_WIDTH-1:0]   remainder,
  output logic                   done,
  output logic                   busy,
  output logic                   overflow,
  output logic                   div_by_zero
);

  localparam int BW = BIT_WIDTH;
  localparam int DW = 2 * BIT_WIDTH;
  localparam int CW = $clog2(DW);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic signed [DW:0] Q_MAX   = {{(DW-BW+2){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [DW:0] Q_MIN   = {{(DW-BW+2){1'b1}}, {(BW-1){1'b0}}};
  localparam logic [BW-1:0]      SAT_POS = {1'b0, {(BW-1){1'b1}}};
  localparam logic [BW-1:0]      SAT_NEG = {1'b1, {(BW-1){1'b0}}};

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW:0]   rem_q, rem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [BW:0]   dvs_q, dvs_d;
  logic          sign_dd_q, sign_dd_d;
  logic          sign_dv_q, sign_dv_d;
  logic          dvz_q, dvz_d;
  logic [BW-1:0] quotient_q, quotient_d;
  logic [BW-1:0] remainder_q, remainder_d;
  logic          overflow_q, overflow_d;
  logic          div_by_zero_q, div_by_zero_d;

  logic                 accept;
  logic [BW:0]          dv_ext;
  logic [BW:0]          rem_sh;
  logic                 rem_ge;
  logic [DW:0]          q_mag;
  logic signed [DW:0]   q_signed;
  logic                 q_ovf;
  logic                 unused_rem_msb;

  // Remainder stays below |divisor| <= 2^(BW-1), so its top bit never feeds the next shift.
  assign unused_rem_msb = rem_q[BW];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    sign_dd_d     = sign_dd_q;
    sign_dv_d     = sign_dv_q;
    dvz_d         = dvz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    overflow_d    = overflow_q;
    div_by_zero_d = div_by_zero_q;

    accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    dv_ext   = {divisor[BW-1], divisor};
    rem_sh   = {rem_q[BW-1:0], quo_q[DW-1]};
    rem_ge   = (rem_sh >= dvs_q);
    q_mag    = {1'b0, quo_q};
    q_signed = (sign_dd_q ^ sign_dv_q) ? -q_mag : q_mag;
    q_ovf    = (q_signed > Q_MAX) || (q_signed < Q_MIN);

    case (state_q)
      S_CALC: begin
        if (!dvz_q) begin
          rem_d = rem_ge ? (rem_sh - dvs_q) : rem_sh;
          quo_d = {quo_q[DW-2:0], rem_ge};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW-1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (dvz_q) begin
          quotient_d    = sign_dd_q ? SAT_NEG : SAT_POS;
          remainder_d   = '0;
          overflow_d    = 1'b0;
          div_by_zero_d = 1'b1;
        end else begin
          quotient_d    = q_ovf ? (q_signed[DW] ? SAT_NEG : SAT_POS) : q_signed[BW-1:0];
          remainder_d   = sign_dd_q ? -rem_q[BW-1:0] : rem_q[BW-1:0];
          overflow_d    = q_ovf;
          div_by_zero_d = 1'b0;
        end
        state_d = S_DONE;
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
        if (state_q == S_DONE) state_d = S_IDLE;
        if (accept) begin
          sign_dd_d = dividend[DW-1];
          sign_dv_d = divisor[BW-1];
          quo_d     = dividend[DW-1] ? -dividend : dividend;
          dvs_d     = divisor[BW-1] ? -dv_ext : dv_ext;
          dvz_d     = (divisor == '0);
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = S_CALC;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      sign_dd_q     <= 1'b0;
      sign_dv_q     <= 1'b0;
      dvz_q         <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      overflow_q    <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvs_q         <= dvs_d;
      sign_dd_q     <= sign_dd_d;
      sign_dv_q     <= sign_dv_d;
      dvz_q         <= dvz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      overflow_q    <= overflow_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign overflow    = overflow_q;
  assign div_by_zero = div_by_zero_q;
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q == S_CALC) || (state_q == S_FIX);

endmodule
